// File: rtl/audio_pkg.sv
// Shared audio-path definitions used by the PDM capture, serializer and controller blocks.
package audio_pkg;

    localparam int unsigned SAMPLE_W             = 16;
    localparam int unsigned PDM_CLK_HALF_DEFAULT = 25;
    localparam int unsigned PDM_DECIM_DEFAULT    = 128;

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic {
        PDM_IDLE = 1'b0,
        PDM_RUN  = 1'b1
    } pdm_state_t;

endpackage

// File: rtl/pdm_clock_gen.sv
// Microphone clock divider: registered 50% duty pdm_clk_o and an end-of-high-phase sample strobe.
module pdm_clock_gen
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HALF = PDM_CLK_HALF_DEFAULT
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic run,
    output logic pdm_clk_o,
    output logic sample_stb
);

    localparam int unsigned       DIV_W    = $clog2(CLK_HALF);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_HALF - 1);

    logic [DIV_W-1:0] div_q;

    // Dropping run parks the divider with the clock low so re-entry starts a clean low phase.
    always_ff @(posedge clock_i) begin
        if (reset_i || !run) begin
            div_q     <= '0;
            pdm_clk_o <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q     <= '0;
            pdm_clk_o <= ~pdm_clk_o;
        end else begin
            div_q     <= div_q + DIV_W'(1);
        end
    end

    // Bit is taken on the cycle that ends the high phase, together with the falling toggle.
    assign sample_stb = run && (div_q == DIV_LAST) && pdm_clk_o;

endmodule

// File: rtl/pdm_capture.sv
// PDM microphone capture: drives the mic clock, counts ones over a DECIM-bit window and emits
// a saturated, left-justified 16-bit PCM sample with a one-cycle done pulse.
module pdm_capture
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HALF = PDM_CLK_HALF_DEFAULT,
    parameter int unsigned DECIM    = PDM_DECIM_DEFAULT
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                enable_i,
    output logic                done_o,
    output logic [SAMPLE_W-1:0] data_o,
    output logic                pdm_clk_o,
    input  logic                pdm_data_i,
    output logic                pdm_lrsel_o
);

    localparam int unsigned DECIM_W = $clog2(DECIM);
    localparam int unsigned ONES_W  = DECIM_W + 1;
    localparam int unsigned SHIFT   = SAMPLE_W - DECIM_W;

    localparam logic [DECIM_W-1:0] BIT_LAST = DECIM_W'(DECIM - 1);
    localparam logic [ONES_W-1:0]  ONES_MAX = ONES_W'(DECIM - 1);

    pdm_state_t          state_q, state_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic [DECIM_W-1:0]  bitcnt_q, bitcnt_d;
    logic                done_d;
    sample_t             data_d;

    logic                run;
    logic                sample_stb;
    logic [ONES_W-1:0]   ones_sum;
    logic [ONES_W-1:0]   ones_sat;

    // Clock only advances while RUN is held; a falling enable stops it on the same edge.
    assign run = (state_q == PDM_RUN) && enable_i;

    pdm_clock_gen #(
        .CLK_HALF   (CLK_HALF)
    ) u_clock_gen (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .run        (run),
        .pdm_clk_o  (pdm_clk_o),
        .sample_stb (sample_stb)
    );

    // A full window of ones would need one extra code; clamp to the top representable value.
    assign ones_sum = ones_q + ONES_W'(pdm_data_i);
    assign ones_sat = (ones_sum > ONES_MAX) ? ONES_MAX : ones_sum;

    assign pdm_lrsel_o = 1'b0;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= PDM_IDLE;
            ones_q   <= '0;
            bitcnt_q <= '0;
            done_o   <= 1'b0;
            data_o   <= '0;
        end else begin
            state_q  <= state_d;
            ones_q   <= ones_d;
            bitcnt_q <= bitcnt_d;
            done_o   <= done_d;
            data_o   <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ones_d   = ones_q;
        bitcnt_d = bitcnt_q;
        done_d   = 1'b0;
        data_d   = data_o;

        unique case (state_q)
            PDM_IDLE: begin
                ones_d   = '0;
                bitcnt_d = '0;
                if (enable_i) begin
                    state_d = PDM_RUN;
                end
            end
            PDM_RUN: begin
                if (!enable_i) begin
                    // Partial window is dropped, even if this was the closing bit.
                    state_d  = PDM_IDLE;
                    ones_d   = '0;
                    bitcnt_d = '0;
                end else if (sample_stb) begin
                    if (bitcnt_q == BIT_LAST) begin
                        done_d   = 1'b1;
                        data_d   = SAMPLE_W'(ones_sat) << SHIFT;
                        ones_d   = '0;
                        bitcnt_d = '0;
                    end else begin
                        ones_d   = ones_sum;
                        bitcnt_d = bitcnt_q + DECIM_W'(1);
                    end
                end
            end
            default: begin
                state_d = PDM_IDLE;
            end
        endcase
    end

endmodule

// File: doc/pdm_capture.md
# pdm_capture

Capture front end for the PDM microphone on the record path. It generates the microphone clock and samples the 1-bit PDM stream. It decimates that stream to 16-bit PCM samples with a boxcar ones-counter and presents each sample with a one-cycle done pulse. It sits between the microphone pins and the record controller/memory write path, as the deserializer stage.

## Interface
Parameters:
- CLK_HALF, default 25: system cycles per half period of pdm_clk_o (100 MHz / 50 = 2 MHz). Legal range is ≥2.
- DECIM, default 128: PDM bits per output sample. Must be a power of two, 2..32768.

Ports:
- clock_i  input  1  100 MHz system clock. This is the block's only clock.
- reset_i  input  1  Reset, synchronous and active-high.
- enable_i  input  1  Capture enable, level-sensitive, driven by the controller.
- done_o  output  1  One-cycle pulse: a new sample is on data_o.
- data_o  output  16  Latest PCM sample, unsigned and left-justified.
- pdm_clk_o  output  1  Microphone clock.
- pdm_data_i  input  1  PDM bit from the microphone, already stable at sample time.
- pdm_lrsel_o  output  1  Channel select. Tied to 0 (left channel).

## Operation
- States:
  - IDLE: pdm_clk_o=0, divider and accumulator cleared.
  - RUN: clock generated, bits accumulated.
- Transitions:
  - IDLE→RUN on the edge where enable_i=1.
  - RUN→IDLE on the edge where enable_i=0.
- Divider (RUN only):
  - div counts 0..CLK_HALF-1 and wraps.
  - At div==CLK_HALF-1, pdm_clk_o toggles.
- Sampling:
  - A bit is taken when div==CLK_HALF-1 and pdm_clk_o==1, i.e. at the end of the high phase, coincident with the falling toggle.
  - ones += pdm_data_i; bitcnt += 1.
- Accumulator widths:
  - ones is log2(DECIM)+1 bits.
  - bitcnt is log2(DECIM) bits.
- Window end (bitcnt==DECIM-1 at a sample):
  - sat = min(ones_final, DECIM-1).
  - data_o = sat << (16-log2(DECIM)), zero-filled low bits.
  - done_o=1 for one cycle.
  - ones and bitcnt restart at 0.
  - The final bit counts toward the closing window only.
- data_o holds its value between done pulses and across IDLE.
- Disable mid-window: the partial window is discarded and no done is produced. This includes the case where enable_i falls on the cycle the final bit would be sampled.
- Re-enable always starts a fresh window with pdm_clk_o low.
- pdm_lrsel_o is constant 0.

## Timing
- Reset values: done_o=0, data_o=16'h0000, pdm_clk_o=0, pdm_lrsel_o=0, state=IDLE, counters 0.
- reset_i overrides enable_i and takes effect at the next edge, including mid-window.
- Let t=0 be the first RUN cycle. With defaults:
  - pdm_clk_o rises at t=25 and falls at t=50.
  - Bit n is sampled at t=50n-1.
- First done_o is at t=50·DECIM (6400 by default); data_o is valid in the same cycle.
- Subsequent done pulses come every 2·CLK_HALF·DECIM cycles (15.625 kHz by default).
- pdm_clk_o is a registered output with duty exactly 50% in RUN.
- No glitches occur on RUN↔IDLE transitions.

## Structure
- A shared package audio_pkg holds:
  - SAMPLE_W=16
  - typedef logic [SAMPLE_W-1:0] sample_t
  - PDM_CLK_HALF_DEFAULT=25
  - PDM_DECIM_DEFAULT=128
- The Serializer and Controller use the same package.
- Sub-module pdm_clock_gen contains the divider and pdm_clk_o register. It emits a one-cycle sample_stb (div==CLK_HALF-1 && clk high).
- pdm_capture holds the FSM, accumulator and output register.

## Test plan
- Reset then enable, pdm_data_i constant 1:
  - pdm_clk_o rises at t=25.
  - First done_o at t=6400 with data_o=16'hFE00 (128 saturates to 127, <<9).
- pdm_data_i constant 0 → done_o every 6400 cycles, data_o=16'h0000.
- Alternating 1/0 per PDM bit (64 ones) → data_o=16'h8000.
- Bit-level checks:
  - Drive pdm_data_i=1 only at sample points t=50n-1 for n=1..10 and 0 elsewhere → data_o=10<<9=16'h1400.
  - Drive 1 only off-sample-point → 0.
- Disable at t=3000, re-enable 100 cycles later with constant 1:
  - No done before the re-enable.
  - pdm_clk_o low during IDLE.
  - Next done 6400 cycles after re-entry, with data_o=16'hFE00.
- Mid-run resets:
  - Assert reset_i at t=6399 → no done; all outputs return to reset values next cycle.
  - Parameter sweep with CLK_HALF=2, DECIM=2 and constant 1 → done every 8 cycles, data_o=16'h8000.
